// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding for the register file and its clear sequencer
package regfile_pkg;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: INIT/RUN sequencer sweeping zeros through the array after reset or clr
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output state_e            state,
  output logic [ADDR_W-1:0] cnt,
  output logic              zero_we,
  output logic              ready
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  always_comb begin
    state_d = clr ? INIT : (state_q == INIT && cnt_q == '1) ? RUN : state_q;
    cnt_d   = (clr || state_q == RUN) ? '0 : cnt_q + 1'b1;
    ready_d = state_d == RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end
  assign state   = state_q;
  assign cnt     = cnt_q;
  assign zero_we = state_q == INIT;
  assign ready   = ready_q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with zeroing sweep, optional r0 hardwire and write bypass
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              re,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready
);
  localparam int NREGS = 2 ** ADDR_W;
  state_e            state;
  logic [ADDR_W-1:0] cnt, wr_addr;
  logic              zero_we, run, user_we, wr_en, rd_en;
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, wr_data;
  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .state  (state),
    .cnt    (cnt),
    .zero_we(zero_we),
    .ready  (ready)
  );
  // user_we is the write that actually lands; it also qualifies the bypass path
  always_comb begin
    run     = state == RUN;
    user_we = run && we && !clr && !(ZERO_REG != 0 && rd == '0);
    wr_en   = zero_we || user_we;
    wr_addr = zero_we ? cnt : rd;
    wr_data = zero_we ? '0 : data_in;
    rd_en   = run && re;
    a_d = !rd_en ? a_q : (ZERO_REG != 0 && rs == '0) ? '0 :
          (BYPASS != 0 && user_we && rd == rs) ? data_in : mem_q[rs];
    b_d = !rd_en ? b_q : (ZERO_REG != 0 && rt == '0) ? '0 :
          (BYPASS != 0 && user_we && rd == rt) ? data_in : mem_q[rt];
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign A = a_q;
  assign B = b_q;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed table-driven check of three parameter variants sharing one stimulus
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, re = 1'b0, we = 1'b0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] data_in = '0;
  logic [15:0] a_d, b_d, a_n, b_n, a_z, b_z;
  logic        rdy_d, rdy_n, rdy_z;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [15:0] din;
    logic        re;
    logic [4:0]  rs, rt;
    logic [15:0] ea, eb, ena, enb, eza, ezb;
  } vec_t;
  vec_t tbl[11];

  regfile_param #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .clr(clr), .re(re), .rs(rs), .rt(rt), .A(a_d), .B(b_d),
    .we(we), .rd(rd), .data_in(data_in), .ready(rdy_d));
  regfile_param #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .clr(clr), .re(re), .rs(rs), .rt(rt), .A(a_n), .B(b_n),
    .we(we), .rd(rd), .data_in(data_in), .ready(rdy_n));
  regfile_param #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .clr(clr), .re(re), .rs(rs), .rt(rt), .A(a_z), .B(b_z),
    .we(we), .rd(rd), .data_in(data_in), .ready(rdy_z));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string name, input logic exp);
    chk({name, "_d"}, {15'b0, rdy_d}, {15'b0, exp});
    chk({name, "_n"}, {15'b0, rdy_n}, {15'b0, exp});
    chk({name, "_z"}, {15'b0, rdy_z}, {15'b0, exp});
  endtask

  task automatic sweep_check(input string name);
    for (int i = 0; i < 32; i++) begin
      chk_rdy(name, 1'b0);
      step();
    end
    chk_rdy({name, "_done"}, 1'b1);
  endtask

  initial begin
    //          we    rd     din       re    rs     rt     ea       eb       ena      enb      eza      ezb
    tbl[0]  = '{1'b1, 5'd5,  16'hBEEF, 1'b0, 5'd0,  5'd0,  16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0};
    tbl[1]  = '{1'b0, 5'd0,  16'h0,    1'b1, 5'd5,  5'd0,  16'hBEEF,16'h0,   16'hBEEF,16'h0,   16'hBEEF,16'h0};
    tbl[2]  = '{1'b0, 5'd0,  16'h0,    1'b0, 5'd0,  5'd0,  16'hBEEF,16'h0,   16'hBEEF,16'h0,   16'hBEEF,16'h0};
    tbl[3]  = '{1'b1, 5'd7,  16'h1234, 1'b1, 5'd7,  5'd7,  16'h1234,16'h1234,16'h0,   16'h0,   16'h1234,16'h1234};
    tbl[4]  = '{1'b0, 5'd0,  16'h0,    1'b1, 5'd7,  5'd5,  16'h1234,16'hBEEF,16'h1234,16'hBEEF,16'h1234,16'hBEEF};
    tbl[5]  = '{1'b1, 5'd0,  16'hFFFF, 1'b1, 5'd0,  5'd7,  16'hFFFF,16'h1234,16'h0,   16'h1234,16'h0,   16'h1234};
    tbl[6]  = '{1'b0, 5'd0,  16'h0,    1'b1, 5'd0,  5'd0,  16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'h0,   16'h0};
    tbl[7]  = '{1'b1, 5'd9,  16'h1111, 1'b1, 5'd9,  5'd5,  16'h1111,16'hBEEF,16'h0,   16'hBEEF,16'h1111,16'hBEEF};
    tbl[8]  = '{1'b1, 5'd9,  16'h2222, 1'b1, 5'd9,  5'd9,  16'h2222,16'h2222,16'h1111,16'h1111,16'h2222,16'h2222};
    tbl[9]  = '{1'b1, 5'd31, 16'h8001, 1'b0, 5'd31, 5'd31, 16'h2222,16'h2222,16'h1111,16'h1111,16'h2222,16'h2222};
    tbl[10] = '{1'b0, 5'd0,  16'h0,    1'b1, 5'd31, 5'd9,  16'h8001,16'h2222,16'h8001,16'h2222,16'h8001,16'h2222};

    repeat (3) step();
    chk("rst_a", a_d, 16'h0);
    chk("rst_b", b_d, 16'h0);
    chk_rdy("rst_rdy", 1'b0);
    rst_n = 1'b1;
    sweep_check("init_sweep");

    re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(31 - i);
      step();
      chk($sformatf("zero_a_r%0d", i), a_d, 16'h0);
      chk($sformatf("zero_b_r%0d", i), b_d, 16'h0);
    end

    for (int i = 0; i < 11; i++) begin
      we = tbl[i].we; rd = tbl[i].rd; data_in = tbl[i].din;
      re = tbl[i].re; rs = tbl[i].rs; rt = tbl[i].rt;
      step();
      chk($sformatf("v%0d_a_d", i), a_d, tbl[i].ea);
      chk($sformatf("v%0d_b_d", i), b_d, tbl[i].eb);
      chk($sformatf("v%0d_a_n", i), a_n, tbl[i].ena);
      chk($sformatf("v%0d_b_n", i), b_n, tbl[i].enb);
      chk($sformatf("v%0d_a_z", i), a_z, tbl[i].eza);
      chk($sformatf("v%0d_b_z", i), b_z, tbl[i].ezb);
      chk_rdy($sformatf("v%0d_rdy", i), 1'b1);
    end

    // clr wins over a same-cycle write; we held high through the sweep is ignored
    we = 1'b1; rd = 5'd3; data_in = 16'hA5A5; re = 1'b0;
    step();
    we = 1'b0; re = 1'b1; rs = 5'd3; rt = 5'd3;
    step();
    chk("clr_pre_a", a_d, 16'hA5A5);
    clr = 1'b1; we = 1'b1; rd = 5'd4; data_in = 16'h5A5A; re = 1'b0;
    step();
    clr = 1'b0; re = 1'b1; rs = 5'd4; rt = 5'd3;
    for (int i = 0; i < 32; i++) begin
      chk_rdy("clr_sweep", 1'b0);
      chk("clr_hold_a", a_d, 16'hA5A5);
      rd = 5'(i);
      step();
    end
    chk_rdy("clr_done", 1'b1);
    we = 1'b0; rs = 5'd3; rt = 5'd4;
    step();
    chk("clr_r3", a_d, 16'h0);
    chk("clr_r4", b_d, 16'h0);

    // asynchronous reset in the middle of a sweep
    we = 1'b1; rd = 5'd6; data_in = 16'h6666; re = 1'b0;
    step();
    we = 1'b0; re = 1'b1; rs = 5'd6; rt = 5'd6;
    step();
    chk("arst_pre_a", a_d, 16'h6666);
    chk("arst_pre_b", b_d, 16'h6666);
    re = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("arst_a", a_d, 16'h0);
    chk("arst_b", b_d, 16'h0);
    chk("arst_a_n", a_n, 16'h0);
    chk("arst_b_z", b_z, 16'h0);
    chk_rdy("arst_rdy", 1'b0);
    #2;
    rst_n = 1'b1;
    sweep_check("arst_sweep");
    re = 1'b1; rs = 5'd6; rt = 5'd31;
    step();
    chk("arst_r6", a_d, 16'h0);
    chk("arst_r31", b_d, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
